mode_counter: RTL and testbench

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter_if.sv | 27 ++
 rtl/mode_counter.sv | 72 +++++++
 tb/tb_mode_counter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mode_counter_if.sv
// rtl/mode_counter_if.sv - control and status bundle for the bounded up/down counter
interface mode_counter_if #(
  parameter int BITS = 8
);
  logic            clear;
  logic            load;
  logic [BITS-1:0] load_val;
  logic            enable;
  logic            countup;
  logic            countdown;
  logic [BITS-1:0] rollover_val;
  logic            wrap_en;
  logic [BITS-1:0] count_out;
  logic            term_flag;
  logic            wrap_pulse;
  logic            sat_flag;

  modport master (
    output clear, load, load_val, enable, countup, countdown, rollover_val, wrap_en,
    input  count_out, term_flag, wrap_pulse, sat_flag
  );

  modport slave (
    input  clear, load, load_val, enable, countup, countdown, rollover_val, wrap_en,
    output count_out, term_flag, wrap_pulse, sat_flag
  );
endinterface

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down counter bounded by rollover_val, wrapping or saturating at the limits
module mode_counter #(
  parameter int BITS = 8
) (
  input logic           CLK,
  input logic           nRST,
  mode_counter_if.slave bus
);

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_next;
  logic            wrap_q;
  logic            wrap_next;
  logic            sat_q;
  logic            sat_next;
  logic            up_req;
  logic            down_req;

  // Simultaneous up and down requests cancel and are treated as hold.
  assign up_req   = bus.enable & bus.countup & ~bus.countdown;
  assign down_req = bus.enable & bus.countdown & ~bus.countup;

  always_comb begin
    count_next = count_q;
    wrap_next  = 1'b0;
    sat_next   = 1'b0;
    if (bus.clear) begin
      count_next = '0;
    end else if (bus.load) begin
      count_next = bus.load_val;
    end else if (up_req) begin
      // >= so a value loaded above the limit still wraps or saturates.
      if (count_q < bus.rollover_val) begin
        count_next = count_q + ONE;
      end else if (bus.wrap_en) begin
        count_next = '0;
        wrap_next  = 1'b1;
      end else begin
        sat_next   = 1'b1;
      end
    end else if (down_req) begin
      if (count_q != '0) begin
        count_next = count_q - ONE;
      end else if (bus.wrap_en) begin
        count_next = bus.rollover_val;
        wrap_next  = 1'b1;
      end else begin
        sat_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= wrap_next;
      sat_q   <= sat_next;
    end
  end

  assign bus.count_out  = count_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.sat_flag   = sat_q;
  assign bus.term_flag  = (count_q == bus.rollover_val);

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - scoreboard bench for mode_counter with directed vectors
module tb_mode_counter;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  mode_counter_if #(.BITS(4)) bus ();

  mode_counter #(.BITS(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [3:0] cnt;
    logic       wrp;
    logic       sat;
    logic       trm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event probe;

  task automatic push(input string nm, input logic [3:0] c, input logic w, input logic s, input logic t);
    exp_t e;
    e.name = nm;
    e.cnt  = c;
    e.wrp  = w;
    e.sat  = s;
    e.trm  = t;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge, expect the result after the rising edge.
  task automatic step(input string nm,
                      input logic cl, input logic ld, input logic [3:0] lv,
                      input logic en, input logic up, input logic dn,
                      input logic [3:0] rv, input logic we,
                      input logic [3:0] ec, input logic ew, input logic es, input logic et);
    @(negedge CLK);
    bus.clear        = cl;
    bus.load         = ld;
    bus.load_val     = lv;
    bus.enable       = en;
    bus.countup      = up;
    bus.countdown    = dn;
    bus.rollover_val = rv;
    bus.wrap_en      = we;
    @(posedge CLK);
    push(nm, ec, ew, es, et);
  endtask

  task automatic chk(input string nm, input string field, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK or probe);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "count_out",  bus.count_out,          e.cnt);
        chk(e.name, "wrap_pulse", {3'b0, bus.wrap_pulse}, {3'b0, e.wrp});
        chk(e.name, "sat_flag",   {3'b0, bus.sat_flag},   {3'b0, e.sat});
        chk(e.name, "term_flag",  {3'b0, bus.term_flag},  {3'b0, e.trm});
        chk(e.name, "flag_excl",  {3'b0, bus.wrap_pulse & bus.sat_flag}, 4'd0);
      end
    end
  end

  initial begin
    bus.clear = 0; bus.load = 0; bus.load_val = 0; bus.enable = 0;
    bus.countup = 0; bus.countdown = 0; bus.rollover_val = 4'd5; bus.wrap_en = 0;

    @(negedge CLK);
    push("reset", 4'd0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;

    //           name        cl ld lv    en up dn rv     we  cnt   w  s  t
    step("wrap_up1",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd1, 0, 0, 0);
    step("wrap_up2",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd2, 0, 0, 0);
    step("wrap_up3",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd3, 0, 0, 0);
    step("wrap_up4",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd4, 0, 0, 0);
    step("wrap_up5",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd5, 0, 0, 1);
    step("wrap_up6",  0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd0, 1, 0, 0);
    step("idle",      0, 0, 4'd0, 0, 0, 0, 4'd5,  1, 4'd0, 0, 0, 0);
    step("sat_dn1",   0, 0, 4'd0, 1, 0, 1, 4'd5,  0, 4'd0, 0, 1, 0);
    step("sat_dn2",   0, 0, 4'd0, 1, 0, 1, 4'd5,  0, 4'd0, 0, 1, 0);
    step("sat_dn3",   0, 0, 4'd0, 1, 0, 1, 4'd5,  0, 4'd0, 0, 1, 0);
    step("sat_stop",  0, 0, 4'd0, 1, 0, 0, 4'd5,  0, 4'd0, 0, 0, 0);
    step("prio_clr",  1, 1, 4'd9, 1, 1, 0, 4'd5,  1, 4'd0, 0, 0, 0);
    step("prio_load", 0, 1, 4'd9, 0, 0, 0, 4'd5,  1, 4'd9, 0, 0, 0);
    step("prio_wrap", 0, 0, 4'd0, 1, 1, 0, 4'd5,  1, 4'd0, 1, 0, 0);
    step("above_ld",  0, 1, 4'd9, 0, 0, 0, 4'd5,  1, 4'd9, 0, 0, 0);
    step("above_dn",  0, 0, 4'd0, 1, 0, 1, 4'd5,  1, 4'd8, 0, 0, 0);
    step("clr",       1, 0, 4'd0, 0, 0, 0, 4'd12, 1, 4'd0, 0, 0, 0);
    step("dn_wrap",   0, 0, 4'd0, 1, 0, 1, 4'd12, 1, 4'd12, 1, 0, 1);
    step("sat_up",    0, 0, 4'd0, 1, 1, 0, 4'd12, 0, 4'd12, 0, 1, 1);
    step("conflict1", 0, 0, 4'd0, 1, 1, 1, 4'd12, 0, 4'd12, 0, 0, 1);
    step("load3",     0, 1, 4'd3, 0, 0, 0, 4'd12, 1, 4'd3, 0, 0, 0);
    step("conflict2", 0, 0, 4'd0, 1, 1, 1, 4'd12, 1, 4'd3, 0, 0, 0);
    step("disabled",  0, 0, 4'd0, 0, 1, 0, 4'd12, 1, 4'd3, 0, 0, 0);
    step("rv0_up",    0, 0, 4'd0, 1, 1, 0, 4'd0,  1, 4'd0, 1, 0, 1);
    step("rv0_dn",    0, 0, 4'd0, 1, 0, 1, 4'd0,  1, 4'd0, 1, 0, 1);

    // rollover_val change between edges must show on term_flag immediately
    @(negedge CLK);
    bus.enable = 0; bus.countup = 0; bus.countdown = 0;
    bus.rollover_val = 4'd7;
    -> probe;
    push("term_comb", 4'd0, 1, 0, 0);

    step("ones_ld",   0, 1, 4'd15, 0, 0, 0, 4'd15, 0, 4'd15, 0, 0, 1);
    step("ones_sat",  0, 0, 4'd0,  1, 1, 0, 4'd15, 0, 4'd15, 0, 1, 1);
    step("ones_wrap", 0, 0, 4'd0,  1, 1, 0, 4'd15, 1, 4'd0,  1, 0, 0);
    step("ld7",       0, 1, 4'd7,  0, 0, 0, 4'd15, 1, 4'd7,  0, 0, 0);

    // reset asserted between edges with an up request in flight
    @(negedge CLK);
    bus.load = 0; bus.enable = 1; bus.countup = 1;
    #2;
    nRST = 1'b0;
    -> probe;
    push("async_rst", 4'd0, 0, 0, 0);
    #2;
    nRST = 1'b1;
    @(posedge CLK);
    push("post_rst", 4'd1, 0, 0, 0);

    @(negedge CLK);
    bus.enable = 0; bus.countup = 0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
